mdio_slave_regs: RTL

//  MDIO (Clause 22) responder: the PHY-side end of the management interface. Oversamples
//  MDC/MDIO in the clk domain, decodes PRE/ST/OP/PHYAD/REGAD/TA, and serves a 32x16 register

---
 rtl/mdio_slave_regs_if.sv | 21 ++
 rtl/mdio_slave_regs.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mdio_slave_regs_if.sv
// MDIO management bus plus register-write side channel for mdio_slave_regs.
interface mdio_slave_regs_if;
    logic        mdc;
    logic        mdio_i;
    logic        mdio_o;
    logic        mdio_oe;
    logic        reg_wr_en;
    logic [4:0]  reg_wr_addr;
    logic [15:0] reg_wr_data;
    logic        frame_err;

    modport slave (
        input  mdc, mdio_i,
        output mdio_o, mdio_oe, reg_wr_en, reg_wr_addr, reg_wr_data, frame_err
    );

    modport master (
        output mdc, mdio_i,
        input  mdio_o, mdio_oe, reg_wr_en, reg_wr_addr, reg_wr_data, frame_err
    );
endinterface

// File: rtl/mdio_slave_regs.sv
// Clause 22 MDIO responder with a 32x16 register file. MDC/MDIO are oversampled
// in the clk domain; decode advances on detected MDC rises, read data is driven
// on detected MDC falls.
module mdio_slave_regs #(
    parameter logic [4:0]  PHY_ADDR = 5'b00001,
    parameter logic [5:0]  PRE_LEN  = 6'd32,
    parameter logic [15:0] PHY_ID1  = 16'h004D,
    parameter logic [15:0] PHY_ID2  = 16'hD072
) (
    input  logic clk,
    input  logic rst_n,
    mdio_slave_regs_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_SKIP, S_WTA, S_WDATA, S_RD
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  mdc_sync, mdio_sync;
    logic        mdc_dly;
    logic        rise, fall, bit_in;
    logic [5:0]  pre_cnt;
    logic [4:0]  cnt;        // rises within the current field
    logic [4:0]  fcnt;       // falls since the last REGAD rise of a read
    logic [1:0]  op;
    logic [4:0]  phyad, regad, regad_full;
    logic [14:0] wsh;
    logic [15:0] wdata_full, rd_shift, rd_word;
    logic [15:0] regs [32];
    logic        err, commit, load_rd;
    logic        mdio_o_q, mdio_oe_q, wr_en_q, frame_err_q;
    logic [4:0]  wr_addr_q;
    logic [15:0] wr_data_q;

    assign rise       = mdc_sync[1] & ~mdc_dly;
    assign fall       = ~mdc_sync[1] & mdc_dly;
    assign bit_in     = mdio_sync[1];
    assign regad_full = {regad[3:0], bit_in};
    assign wdata_full = {wsh, bit_in};

    // Read source: ID registers are constants, everything else comes from the file
    always_comb begin
        rd_word = regs[regad_full];
        if (regad_full == 5'd2) rd_word = PHY_ID1;
        if (regad_full == 5'd3) rd_word = PHY_ID2;
    end

    // Two-stage synchronisers plus a delayed MDC copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdc_sync  <= 2'b00;
            mdio_sync <= 2'b11;
            mdc_dly   <= 1'b0;
        end else begin
            mdc_sync  <= {mdc_sync[0], bus.mdc};
            mdio_sync <= {mdio_sync[0], bus.mdio_i};
            mdc_dly   <= mdc_sync[1];
        end
    end

    // Frame decoder state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and per-bit strobes; fields advance one bit per MDC rise
    always_comb begin
        state_nxt = state;
        err       = 1'b0;
        commit    = 1'b0;
        load_rd   = 1'b0;
        if (rise) begin
            case (state)
                S_IDLE:  if (!bit_in && pre_cnt >= PRE_LEN) state_nxt = S_ST;
                S_ST:    if (bit_in) state_nxt = S_OP;
                         else begin err = 1'b1; state_nxt = S_IDLE; end
                S_OP:    if (cnt == 5'd1) begin
                             if ({op[0], bit_in} == 2'b01 || {op[0], bit_in} == 2'b10)
                                 state_nxt = S_PHYAD;
                             else begin err = 1'b1; state_nxt = S_IDLE; end
                         end
                S_PHYAD: if (cnt == 5'd4) state_nxt = S_REGAD;
                S_REGAD: if (cnt == 5'd4) begin
                             if (phyad != PHY_ADDR) state_nxt = S_SKIP;
                             else if (op == 2'b10) begin
                                 state_nxt = S_RD;
                                 load_rd   = 1'b1;
                             end else state_nxt = S_WTA;
                         end
                S_SKIP:  if (cnt == 5'd17) state_nxt = S_IDLE;
                S_WTA:   if (cnt == 5'd1) state_nxt = S_WDATA;
                S_WDATA: if (cnt == 5'd15) begin
                             commit    = 1'b1;
                             state_nxt = S_IDLE;
                         end
                default: ;
            endcase
        end else if (fall && state == S_RD && fcnt == 5'd18) begin
            state_nxt = S_IDLE;
        end
    end

    // Field shift registers, bit/preamble counters and the write/error strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt     <= '0;
            cnt         <= '0;
            op          <= '0;
            phyad       <= '0;
            regad       <= '0;
            wsh         <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            wr_en_q     <= commit;
            frame_err_q <= err;
            if (state_nxt != state) cnt <= '0;
            else if (rise)          cnt <= cnt + 5'd1;
            if (state != S_IDLE) pre_cnt <= '0;
            else if (rise) begin
                if (!bit_in)                pre_cnt <= '0;
                else if (pre_cnt != 6'd32)  pre_cnt <= pre_cnt + 6'd1;
            end
            if (rise) begin
                case (state)
                    S_OP:    op    <= {op[0], bit_in};
                    S_PHYAD: phyad <= {phyad[3:0], bit_in};
                    S_REGAD: regad <= regad_full;
                    S_WDATA: wsh   <= {wsh[13:0], bit_in};
                    default: ;
                endcase
            end
            if (commit) begin
                wr_addr_q <= regad;
                wr_data_q <= wdata_full;
            end
        end
    end

    // Register file; writes to the ID addresses still pulse but are not stored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (commit && regad != 5'd2 && regad != 5'd3) begin
            regs[regad] <= wdata_full;
        end
    end

    // Read drive: fall 2 acks with 0, falls 3..18 shift data out, fall 19 releases
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt      <= '0;
            rd_shift  <= '0;
            mdio_o_q  <= 1'b1;
            mdio_oe_q <= 1'b0;
        end else if (load_rd) begin
            fcnt     <= '0;
            rd_shift <= rd_word;
        end else if (fall && state == S_RD) begin
            fcnt <= fcnt + 5'd1;
            if (fcnt == 5'd1) begin
                mdio_oe_q <= 1'b1;
                mdio_o_q  <= 1'b0;
            end else if (fcnt == 5'd18) begin
                mdio_oe_q <= 1'b0;
                mdio_o_q  <= 1'b1;
            end else if (fcnt >= 5'd2) begin
                mdio_o_q <= rd_shift[15];
                rd_shift <= {rd_shift[14:0], 1'b0};
            end
        end
    end

    assign bus.mdio_o      = mdio_o_q;
    assign bus.mdio_oe     = mdio_oe_q;
    assign bus.reg_wr_en   = wr_en_q;
    assign bus.reg_wr_addr = wr_addr_q;
    assign bus.reg_wr_data = wr_data_q;
    assign bus.frame_err   = frame_err_q;
endmodule
